// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit: operation codes,
// FSM states and the default datapath width.
package mdu_pkg;

  localparam int MDU_WIDTH = 32;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FINISH
  } mdu_state_e;

  function automatic logic is_iter_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// One combinational iteration of the MDU datapath: an unsigned shift-add
// multiply step or a restoring shift-subtract divide step on magnitudes.
module mdu_iter_core
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] hi_next,
  output logic [WIDTH-1:0] lo_next
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic           take;

  always_comb begin
    sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : '0);
    // Partial remainder can reach WIDTH+1 bits before the trial subtract.
    shifted = {acc_hi, acc_lo[WIDTH-1]};
    take    = (shifted >= {1'b0, operand});
    hi_next = '0;
    lo_next = '0;
    if (is_div) begin
      hi_next = take ? (shifted[WIDTH-1:0] - operand) : shifted[WIDTH-1:0];
      lo_next = {acc_lo[WIDTH-2:0], take};
    end else begin
      hi_next = sum[WIDTH:1];
      lo_next = {sum[0], acc_lo[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MIPS HI/LO multiply/divide unit (MULT/MULTU/DIV/DIVU, MTHI/MTLO).
// Optional MDU_DIV0_FLAG_EN adds an MDU_div0 pulse alongside MDU_done.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             MDU_clk,
  input  logic             MDU_rst,
  input  logic             MDU_start,
  input  logic [2:0]       MDU_op,
  input  logic [WIDTH-1:0] MDU_a,
  input  logic [WIDTH-1:0] MDU_b,
  output logic             MDU_busy,
  output logic             MDU_done,
  output logic [WIDTH-1:0] MDU_hi,
  output logic [WIDTH-1:0] MDU_lo
`ifdef MDU_DIV0_FLAG_EN
  ,
  output logic             MDU_div0
`endif
);

  // Handshake: MDU_start is the valid, !MDU_busy the ready; a request transfers
  // on a rising edge where both hold, and starts seen while busy are dropped.
  mdu_state_e       state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc_hi, acc_lo, operand;
  logic [WIDTH-1:0] hi_r, lo_r, core_hi, core_lo;
  logic [WIDTH-1:0] a_mag, b_mag, res_hi, res_lo;
  logic [2*WIDTH-1:0] prod_fix;
  logic             is_div, neg_lo, neg_hi, div0, done_r;
  logic             op_signed, op_div, start_iter;

  always_comb begin
    op_signed  = (MDU_op == OP_MULT) || (MDU_op == OP_DIV);
    op_div     = (MDU_op == OP_DIV) || (MDU_op == OP_DIVU);
    start_iter = (state == ST_IDLE) && MDU_start && is_iter_op(MDU_op);
    a_mag      = (op_signed && MDU_a[WIDTH-1]) ? -MDU_a : MDU_a;
    b_mag      = (op_signed && MDU_b[WIDTH-1]) ? -MDU_b : MDU_b;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:   if (start_iter) state_n = ST_CALC;
      ST_CALC:   if (cnt == CNT_W'(1)) state_n = ST_FINISH;
      ST_FINISH: state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase
  end

  mdu_iter_core #(.WIDTH(WIDTH)) u_core (
    .is_div  (is_div),
    .acc_hi  (acc_hi),
    .acc_lo  (acc_lo),
    .operand (operand),
    .hi_next (core_hi),
    .lo_next (core_lo)
  );

  // Sign correction; for divide-by-zero the remainder already equals the dividend.
  always_comb begin
    prod_fix = neg_lo ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    res_hi   = prod_fix[2*WIDTH-1:WIDTH];
    res_lo   = prod_fix[WIDTH-1:0];
    if (is_div) begin
      res_hi = neg_hi ? -acc_hi : acc_hi;
      res_lo = div0 ? '1 : (neg_lo ? -acc_lo : acc_lo);
    end
  end

  always_ff @(posedge MDU_clk) begin
    if (MDU_rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      operand <= '0;
      hi_r    <= '0;
      lo_r    <= '0;
      is_div  <= 1'b0;
      neg_lo  <= 1'b0;
      neg_hi  <= 1'b0;
      div0    <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state  <= state_n;
      done_r <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_iter) begin
            cnt     <= CNT_W'(WIDTH);
            acc_hi  <= '0;
            acc_lo  <= a_mag;
            operand <= b_mag;
            is_div  <= op_div;
            neg_lo  <= op_signed && (MDU_a[WIDTH-1] ^ MDU_b[WIDTH-1]);
            neg_hi  <= (MDU_op == OP_DIV) && MDU_a[WIDTH-1];
            div0    <= op_div && (MDU_b == '0);
          end else if (MDU_start && (MDU_op == OP_MTHI)) begin
            hi_r <= MDU_a;
          end else if (MDU_start && (MDU_op == OP_MTLO)) begin
            lo_r <= MDU_a;
          end
        end
        ST_CALC: begin
          acc_hi <= core_hi;
          acc_lo <= core_lo;
          cnt    <= cnt - CNT_W'(1);
        end
        ST_FINISH: begin
          hi_r   <= res_hi;
          lo_r   <= res_lo;
          done_r <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef MDU_DIV0_FLAG_EN
  logic div0_r;

  always_ff @(posedge MDU_clk) begin
    if (MDU_rst) div0_r <= 1'b0;
    else         div0_r <= (state == ST_FINISH) && is_div && div0;
  end

  assign MDU_div0 = div0_r;
`endif

  assign MDU_busy = (state != ST_IDLE);
  assign MDU_done = done_r;
  assign MDU_hi   = hi_r;
  assign MDU_lo   = lo_r;

endmodule
